// File: rtl/powlib_busmem_pkg.sv
// Shared bus definitions for powlib bus endpoints: byte width, operation codes
// and field offsets of a packed {oper, addr, be, data} bus word.
package powlib_busmem_pkg;

    localparam int POWLIB_BW           = 8;
    localparam int POWLIB_BUS_OP_WRITE = 0;
    localparam int POWLIB_BUS_OP_READ  = 1;

    // LSB positions of each field inside a packed bus word, shared with busfifo users
    function automatic int powlib_bus_data_lsb();
        return 0;
    endfunction

    function automatic int powlib_bus_be_lsb(input int bpd);
        return bpd * POWLIB_BW;
    endfunction

    function automatic int powlib_bus_addr_lsb(input int bpd);
        return bpd * POWLIB_BW + bpd;
    endfunction

    function automatic int powlib_bus_oper_lsb(input int bpd, input int aw);
        return bpd * POWLIB_BW + bpd + aw;
    endfunction

endpackage

// File: rtl/powlib_busmem_ram.sv
// D x DW register array with per-byte write enables and asynchronous read.
// Kept separate so a vendor RAM can replace it without touching the bus logic.
module powlib_busmem_ram
    import powlib_busmem_pkg::*;
#(
    parameter int  D   = 4,
    parameter int  BPD = 4,
    parameter int  AW  = 3,
    localparam int DW  = BPD * POWLIB_BW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [BPD-1:0] wbe,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [D];
    logic [DW-1:0] mem_d [D];

    // Full-width address compare per entry: out-of-range addresses match nothing
    always_comb begin
        rdata = '0;
        for (int i = 0; i < D; i++) begin
            mem_d[i] = mem_q[i];
            if (addr == AW'(i)) begin
                rdata = mem_q[i];
                if (we) begin
                    for (int b = 0; b < BPD; b++) begin
                        if (wbe[b]) begin
                            mem_d[i][b*POWLIB_BW +: POWLIB_BW] = wdata[b*POWLIB_BW +: POWLIB_BW];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < D; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/powlib_busmem.sv
// Bus-slave scratch memory: writes update the RAM, reads return one response word.
// Optional miss reporting (err pulse, errcnt, rdbe=0 on read miss) under POWLIB_BUSMEM_ERR_EN.
module powlib_busmem
    import powlib_busmem_pkg::*;
#(
    parameter int    B_BPD = 4,
    parameter int    B_AW  = 2,
    parameter int    B_OW  = 1,
    parameter int    D     = 4,
    parameter int    BASE  = 0,
    parameter string ID    = "BUSMEM",
    parameter int    EDBG  = 0,
    localparam int   B_DW  = B_BPD * POWLIB_BW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [B_DW-1:0]  wrdata,
    input  logic [B_BPD-1:0] wrbe,
    input  logic [B_AW-1:0]  wraddr,
    input  logic [B_OW-1:0]  wroper,
    input  logic             wrvld,
    output logic             wrrdy,
    output logic [B_DW-1:0]  rddata,
    output logic [B_BPD-1:0] rdbe,
    output logic [B_AW-1:0]  rdaddr,
    output logic [B_OW-1:0]  rdoper,
    output logic             rdvld,
`ifdef POWLIB_BUSMEM_ERR_EN
    output logic             err,
    output logic [15:0]      errcnt,
`endif
    input  logic             rdrdy
);

    localparam logic [B_AW:0]   BASE_X = (B_AW+1)'(BASE);
    localparam logic [B_AW:0]   END_X  = (B_AW+1)'(BASE + D);
    localparam logic [B_OW-1:0] OP_RD  = B_OW'(POWLIB_BUS_OP_READ);

    if (D < 1 || D > (1 << B_AW)) begin : g_bad_depth
        $error("%s: depth %0d outside 1..2**B_AW", ID, D);
    end
    if (EDBG != 0) begin : g_edbg
        $info("%s: per-transaction debug display is a simulation-model feature only", ID);
    end

    logic [B_AW:0]    addr_x;
    logic [B_AW:0]    idx;
    logic             hit;
    logic             is_rd;
    logic             acc;
    logic             rd_acc;
    logic             wr_en;
    logic [B_DW-1:0]  ram_rdata;

    logic             rdvld_q,  rdvld_d;
    logic [B_DW-1:0]  rddata_q, rddata_d;
    logic [B_BPD-1:0] rdbe_q,   rdbe_d;
    logic [B_AW-1:0]  rdaddr_q, rdaddr_d;
    logic [B_OW-1:0]  rdoper_q, rdoper_d;
`ifdef POWLIB_BUSMEM_ERR_EN
    logic             err_q,    err_d;
    logic [15:0]      errcnt_q, errcnt_d;
`endif

    // A full response slot stalls every request, so order stays strict
    assign wrrdy = !rdvld_q || rdrdy;

    always_comb begin
        addr_x = {1'b0, wraddr};
        hit    = (addr_x >= BASE_X) && (addr_x < END_X);
        idx    = addr_x - BASE_X;
        is_rd  = (wroper == OP_RD);
        acc    = wrvld && wrrdy && !rst;
        rd_acc = acc && is_rd;
        wr_en  = acc && !is_rd && hit;

        rdvld_d  = rdvld_q;
        rddata_d = rddata_q;
        rdbe_d   = rdbe_q;
        rdaddr_d = rdaddr_q;
        rdoper_d = rdoper_q;
        if (rdvld_q && rdrdy) begin
            rdvld_d = 1'b0;
        end
        if (rd_acc) begin
            rdvld_d  = 1'b1;
            rddata_d = hit ? ram_rdata : '0;
`ifdef POWLIB_BUSMEM_ERR_EN
            rdbe_d   = hit ? wrbe : '0;
`else
            rdbe_d   = wrbe;
`endif
            rdaddr_d = wraddr;
            rdoper_d = OP_RD;
        end

`ifdef POWLIB_BUSMEM_ERR_EN
        err_d    = acc && !hit;
        errcnt_d = errcnt_q;
        if (acc && !hit && errcnt_q != 16'hFFFF) begin
            errcnt_d = errcnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdvld_q  <= 1'b0;
            rddata_q <= '0;
            rdbe_q   <= '0;
            rdaddr_q <= '0;
            rdoper_q <= '0;
`ifdef POWLIB_BUSMEM_ERR_EN
            err_q    <= 1'b0;
            errcnt_q <= '0;
`endif
        end else begin
            rdvld_q  <= rdvld_d;
            rddata_q <= rddata_d;
            rdbe_q   <= rdbe_d;
            rdaddr_q <= rdaddr_d;
            rdoper_q <= rdoper_d;
`ifdef POWLIB_BUSMEM_ERR_EN
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
`endif
        end
    end

    powlib_busmem_ram #(
        .D   (D),
        .BPD (B_BPD),
        .AW  (B_AW + 1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .addr  (idx),
        .wbe   (wrbe),
        .wdata (wrdata),
        .rdata (ram_rdata)
    );

    assign rdvld  = rdvld_q;
    assign rddata = rddata_q;
    assign rdbe   = rdbe_q;
    assign rdaddr = rdaddr_q;
    assign rdoper = rdoper_q;
`ifdef POWLIB_BUSMEM_ERR_EN
    assign err    = err_q;
    assign errcnt = errcnt_q;
`endif

endmodule

// File: doc/powlib_busmem.md
Name: powlib_busmem

Overview:
- Bus-slave memory stage that consumes bus words (data, byte-enable, address, operation) from a bus FIFO read port.
- Writes go into a word-addressed register-array memory under byte enables.
- Reads return one response bus word per request through a valid/ready output port, so a second bus FIFO can sit downstream.
- Used as the default endpoint and scratch RAM behind the bus FIFO in test and integration builds.

Parameters:
- B_BPD, 4, bytes per data word; data width B_DW = B_BPD*`POWLIB_BW
- B_AW, 2, address width in words
- B_OW, 1, operation field width
- D, 4, memory depth in words; legal range 1..2**B_AW
- BASE, 0, first word address mapped to memory entry 0
- ID, "BUSMEM", string identifier for debug messages
- EDBG, 0, enable debug $display of every accepted transaction

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wrdata  in  B_DW  request data
- wrbe  in  B_BPD  request byte enables, 1 bit per byte
- wraddr  in  B_AW  request word address
- wroper  in  B_OW  request operation: POWLIB_BUS_OP_WRITE or POWLIB_BUS_OP_READ
- wrvld  in  1  request valid
- wrrdy  out  1  request ready
- rddata  out  B_DW  response data
- rdbe  out  B_BPD  response byte enables; echoes the request wrbe
- rdaddr  out  B_AW  response address; echoes the request wraddr
- rdoper  out  B_OW  response operation; always POWLIB_BUS_OP_READ
- rdvld  out  1  response valid
- rdrdy  in  1  response ready

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-high.
  - rdvld=0; rddata, rdbe, rdaddr, rdoper = 0.
  - Memory contents are not reset; read-before-write data is undefined.
- Transfer rules:
  - A request transfers on a clk edge when wrvld & wrrdy.
  - A response transfers on a clk edge when rdvld & rdrdy.
- wrrdy = !rdvld | rdrdy.
  - Registered-free combinational path from rdvld/rdrdy only; it never depends on wroper.
  - Writes are also stalled while the response slot is full, which keeps request order strict.
- Address mapping: hit = (wraddr >= BASE) & (wraddr < BASE+D). Memory index = wraddr-BASE, computed at B_AW+1 bits so there is no wrap.
- Accepted write, hit:
  - Byte i of mem[idx] is replaced by byte i of wrdata wherever wrbe[i]=1.
  - Takes effect on the same edge. No response is generated.
- Accepted write, miss: dropped silently.
- Accepted read at edge N:
  - Edge N loads the response register; rdvld=1 from cycle N+1.
  - rddata = mem[idx] (full word, regardless of wrbe) on a hit, 0 on a miss.
  - rdbe, rdaddr are captured from the request; rdoper = POWLIB_BUS_OP_READ.
- Response register:
  - rdvld holds and outputs are stable while rdvld & !rdrdy.
  - rdvld clears at a response transfer unless a new read is accepted on the same edge.
  - Throughput: 1 read per cycle with rdrdy held high.
- Read-after-write: a write accepted at edge N followed by a read of the same address accepted at edge N+1 returns the new data. Only one transaction is handled per cycle, so there is no same-cycle hazard.
- Unknown wroper values (B_OW>1) are treated as writes.
- wrvld asserted during rst: the request is ignored and no state changes.
- Reset mid-operation: a pending response is discarded (rdvld=0); memory keeps its contents.

Optional Feature:
- Macro: POWLIB_BUSMEM_ERR_EN.
- Defined:
  - Adds output port err (1 bit): registered one-cycle pulse on the cycle after any accepted miss (read or write).
  - Adds output port errcnt (16 bits): saturating count of misses, reset to 0.
  - A read miss response sets rdbe = 0 to flag the error.
- Not defined: no extra ports. Misses behave as above, and a read miss echoes wrbe.

Decomposition:
- Shared package powlib_bus.vh:
  - POWLIB_BUS_OP_WRITE=0 and POWLIB_BUS_OP_READ=1.
  - Bus-word field offset macros (data, be, addr, oper), shared with powlib_busfifo users.
  - Include powlib_std.vh for POWLIB_BW.
- One sub-module: powlib_busmem_ram, a D x B_DW byte-enable write, asynchronous-read register array. It keeps the memory inferrable separately and replaceable by a vendor RAM.

Test Plan (B_BPD=4, B_AW=8, D=16, BASE=0x10 throughout):
- Write 0xDEADBEEF be=0xF addr=0x12, then read addr=0x12 -> one response, rddata=0xDEADBEEF, rdaddr=0x12, rdvld high one cycle after acceptance.
- Byte enables: write 0x11223344 be=0x5 addr=0x12 over the previous word, then read -> rddata=0xDE22BE44.
- Backpressure: 4 back-to-back reads of 0x10..0x13 with rdrdy=0 for 5 cycles -> wrrdy=0 after the first accept, response held stable. Release -> 4 responses in order, none lost or duplicated.
- Out of range: write addr=0x05 and addr=0x20, then read addr=0x20 -> memory unchanged, rddata=0. With POWLIB_BUSMEM_ERR_EN: 3 err pulses, errcnt=3, rdbe=0.
- Throughput: 16 reads with rdrdy=1 and wrvld continuous -> 16 responses in 16 consecutive cycles.
- Async reset asserted mid-cycle while rdvld=1 -> rdvld drops immediately. Then read addr=0x12 after reset -> pre-reset data returned.
